// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, default widths
// and the width of one buffered {pc, instr} entry.
package fetch_pkg;

    localparam int unsigned PC_W_DEFAULT    = 5;
    localparam int unsigned INSTR_W_DEFAULT = 16;
    localparam int unsigned ENTRY_W_DEFAULT = PC_W_DEFAULT + INSTR_W_DEFAULT;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

    function automatic int unsigned entry_width(input int unsigned pc_w,
                                                input int unsigned instr_w);
        return pc_w + instr_w;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; head is read straight
// from storage, so a pushed entry becomes visible one cycle after the push.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = ENTRY_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign do_pop  = pop & (count_q != '0);
    // Space is normally reserved upstream; the full guard only protects storage.
    assign do_push = push & ((count_q != FULL_CNT) | do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: accepts a PC, issues one request to instruction memory at a time and
// queues returned instructions, tagged with their PC, for decode. flush drops everything.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEFAULT,
    parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc,
    input  logic               pc_valid,
    output logic               pc_ready,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               flush,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               out_ready
);

    localparam int unsigned ENTRY_W = entry_width(PC_W, INSTR_W);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic             mem_req_q;
    logic             mem_req_d;
    logic [PC_W-1:0]  mem_addr_q;
    logic [PC_W-1:0]  mem_addr_d;
    logic             buf_push;
    logic             buf_pop;
    logic [CNT_W-1:0] buf_count;
    logic [ENTRY_W-1:0] buf_head;

    // Reset gates pc_ready directly so upstream never sees a handshake while held in reset.
    assign pc_ready = reset & (state_q == StIdle) & (buf_count < DEPTH_CNT) & ~flush;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        buf_push   = 1'b0;
        case (state_q)
            StIdle: begin
                if (pc_valid && pc_ready) begin
                    mem_addr_d = pc;
                    mem_req_d  = 1'b1;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (mem_ack) begin
                    buf_push  = ~flush;
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end else if (flush) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                // Request stays up until memory answers; the answer is thrown away.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign buf_pop = out_valid & out_ready;

    fetch_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fetch_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data ({mem_addr_q, mem_rdata}),
        .pop       (buf_pop),
        .clear     (flush),
        .count     (buf_count),
        .head      (buf_head)
    );

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = (buf_count != '0);
    assign out_pc    = buf_head[ENTRY_W-1 -: PC_W];
    assign out_instr = buf_head[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed and random checks of instr_fetch_stage against a queue-based model
// of the fetch/flush rules, with a configurable-latency memory responder.
module tb_instr_fetch_stage;

    localparam int unsigned PC_W    = 5;
    localparam int unsigned INSTR_W = 16;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    logic               clk;
    logic               reset;
    logic [PC_W-1:0]    pc;
    logic               pc_valid;
    logic               pc_ready;
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic               flush;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    ent_t            mq[$];
    bit              m_busy;
    bit              m_drop;
    bit              m_accepted;
    logic [PC_W-1:0] m_addr;
    int              wait_cnt;
    int              mem_lat;
    bit              use_fixed;
    logic [INSTR_W-1:0] fixed_rdata;

    instr_fetch_stage #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .pc_ready  (pc_ready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .flush     (flush),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy     = 0;
        m_drop     = 0;
        m_accepted = 0;
        m_addr     = '0;
        wait_cnt   = 0;
    endtask

    // Called at posedge+1 with inputs already set; runs one clock and checks after it.
    task automatic tick();
        bit   ack;
        bit   acc;
        bit   exp_ready;
        ent_t e;
        ack       = m_busy && (wait_cnt >= mem_lat);
        mem_ack   = ack;
        mem_rdata = use_fixed ? fixed_rdata : INSTR_W'($urandom);
        #1;
        exp_ready = !m_busy && (mq.size() < 2) && !flush;
        chk("pc_ready", 32'(pc_ready), 32'(exp_ready));
        acc = exp_ready && pc_valid;
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (m_busy && ack) begin
            if (!m_drop && !flush) begin
                e.pc    = m_addr;
                e.instr = mem_rdata;
                mq.push_back(e);
            end
            m_busy = 0;
            m_drop = 0;
        end else if (m_busy && flush) begin
            m_drop = 1;
        end
        if (flush) mq.delete();
        if (acc) begin
            m_busy = 1;
            m_drop = 0;
            m_addr = pc;
        end
        m_accepted = acc;
        @(posedge clk);
        #1;
        if (acc) wait_cnt = 0;
        else if (m_busy) wait_cnt++;
        chk("mem_req", 32'(mem_req), 32'(m_busy));
        if (m_busy) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", 32'(out_pc), 32'(mq[0].pc));
            chk("out_instr", 32'(out_instr), 32'(mq[0].instr));
        end
    endtask

    initial begin
        clk         = 0;
        reset       = 0;
        pc          = '0;
        pc_valid    = 0;
        mem_ack     = 0;
        mem_rdata   = '0;
        flush       = 0;
        out_ready   = 0;
        mem_lat     = 0;
        use_fixed   = 0;
        fixed_rdata = '0;
        model_reset();

        // Reset values
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        chk("rst_pc_ready", 32'(pc_ready), 32'd0);
        reset = 1;
        @(posedge clk);
        #1;

        // Zero-wait fetch of pc=4
        pc = 5'd4; pc_valid = 1; out_ready = 1; mem_lat = 0;
        use_fixed = 1; fixed_rdata = 16'hA5A5;
        tick();
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'd4);
        pc_valid = 0;
        tick();
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_pc", 32'(out_pc), 32'd4);
        chk("t1_out_instr", 32'(out_instr), 32'hA5A5);
        tick();
        use_fixed = 0;

        // Ack delayed three cycles
        pc = 5'h0A; pc_valid = 1; mem_lat = 3;
        tick();
        pc_valid = 0;
        repeat (3) begin
            tick();
            chk("t2_mem_req", 32'(mem_req), 32'd1);
            chk("t2_mem_addr", 32'(mem_addr), 32'h0A);
            chk("t2_pc_ready", 32'(pc_ready), 32'd0);
            chk("t2_out_valid_early", 32'(out_valid), 32'd0);
        end
        tick();
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_out_pc", 32'(out_pc), 32'h0A);
        tick();

        // Back-pressure: fill buffer with pc 1,2; pc 3 must wait for a slot
        out_ready = 0; mem_lat = 0; pc = 5'd1; pc_valid = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_accepted) pc = pc + 5'd1;
        end
        chk("t3_full_pc_ready", 32'(pc_ready), 32'd0);
        chk("t3_full_no_req", 32'(mem_req), 32'd0);
        chk("t3_head1", 32'(out_pc), 32'd1);
        out_ready = 1;
        tick();
        chk("t3_head2", 32'(out_pc), 32'd2);
        tick();
        chk("t3_pc3_req", 32'(mem_req), 32'd1);
        chk("t3_pc3_addr", 32'(mem_addr), 32'd3);
        pc_valid = 0;
        tick();
        chk("t3_head3", 32'(out_pc), 32'd3);
        tick();

        // Flush while waiting with one entry buffered; late ack must vanish
        out_ready = 0; mem_lat = 0; pc = 5'd7; pc_valid = 1;
        tick();
        pc_valid = 0;
        tick();
        chk("t4_one_entry", 32'(out_valid), 32'd1);
        mem_lat = 5; pc = 5'd8; pc_valid = 1;
        tick();
        pc_valid = 0; flush = 1;
        tick();
        chk("t4_flush_out_valid", 32'(out_valid), 32'd0);
        chk("t4_drop_mem_req", 32'(mem_req), 32'd1);
        flush = 0; use_fixed = 1; fixed_rdata = 16'hDEAD;
        for (int i = 0; i < 10 && m_busy; i++) tick();
        chk("t4_drop_done", 32'(mem_req), 32'd0);
        chk("t4_dead_hidden", 32'(out_valid), 32'd0);
        chk("t4_pc_ready_back", 32'(pc_ready), 32'd1);
        tick();
        chk("t4_still_empty", 32'(out_valid), 32'd0);
        use_fixed = 0;

        // Flush coincident with ack
        out_ready = 1; mem_lat = 0; pc = 5'd9; pc_valid = 1;
        tick();
        pc_valid = 0; flush = 1;
        tick();
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_mem_req", 32'(mem_req), 32'd0);
        flush = 0;
        #1;
        chk("t5_pc_ready", 32'(pc_ready), 32'd1);

        // Asynchronous reset mid-wait
        mem_lat = 10; pc = 5'h11; pc_valid = 1;
        tick();
        pc_valid = 0;
        tick();
        tick();
        #3;
        reset = 0;
        #1;
        chk("t6_async_mem_req", 32'(mem_req), 32'd0);
        chk("t6_async_out_valid", 32'(out_valid), 32'd0);
        chk("t6_async_pc_ready", 32'(pc_ready), 32'd0);
        chk("t6_async_mem_addr", 32'(mem_addr), 32'd0);
        model_reset();
        mem_ack = 0;
        @(posedge clk);
        #2;
        reset = 1;
        @(posedge clk);
        #1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            pc_valid  = ($urandom_range(0, 3) != 0);
            pc        = PC_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            if (!m_busy) mem_lat = $urandom_range(0, 3);
            tick();
        end
        flush = 0; pc_valid = 0; out_ready = 1;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Consumes the PC produced by increment_program_counter and issues a fetch for that address to instruction memory.
- Holds returned instructions, tagged with their PC, in a 2-entry output buffer for the decode stage.
- Uses valid/ready on the PC side and decode side, and req/ack toward memory.
- flush discards buffered and in-flight fetches when control flow redirects.

Parameters:
- PC_W, 5, width of PC / instruction-memory address
- INSTR_W, 16, instruction word width
- DEPTH, 2, output buffer entries (fixed 2; parameter exists for width derivation only)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 = reset asserted
- pc  input  PC_W  fetch address from program counter
- pc_valid  input  1  pc holds a valid address
- pc_ready  output  1  stage accepts pc this cycle; PC advances on pc_valid&pc_ready
- mem_req  output  1  fetch request to instruction memory
- mem_addr  output  PC_W  fetch address, stable while mem_req=1
- mem_ack  input  1  memory returns mem_rdata this cycle
- mem_rdata  input  INSTR_W  instruction word, valid only with mem_ack
- flush  input  1  discard all buffered and outstanding fetches
- out_valid  output  1  out_instr/out_pc valid (buffer head)
- out_instr  output  INSTR_W  head instruction
- out_pc  output  PC_W  PC of head instruction
- out_ready  input  1  decode consumes head on out_valid&out_ready

Behaviour:
- Reset (reset=0, async): state=IDLE; buffer count=0; mem_req=0, mem_addr=0, out_valid=0, out_instr=0, out_pc=0; pc_ready forced 0 while reset=0.
- FSM states: IDLE, WAIT, DROP.
- pc_ready = (state==IDLE) & (count<DEPTH) & ~flush; combinational, gated by reset.
- IDLE: on pc_valid&pc_ready, mem_addr<=pc, mem_req<=1, go WAIT. Accepted PC is stored with the request for tagging.
- WAIT: mem_req held 1 and mem_addr held stable until mem_ack.
  - mem_ack & ~flush: push {mem_addr, mem_rdata}; mem_req<=0; go IDLE.
  - mem_ack & flush: data discarded; mem_req<=0; go IDLE.
  - ~mem_ack & flush: go DROP.
- DROP: mem_req stays 1 (a request is never withdrawn). On mem_ack: discard data, mem_req<=0, go IDLE. A further flush in DROP has no extra effect.
- Latency, zero-wait memory: accept at edge t; mem_req=1 after t; ack in that cycle; out_valid=1 after edge t+1. Minimum 2 cycles per fetch (pc_ready low in WAIT).
- Buffer: 2-entry FIFO, registered outputs from head. out_valid = count!=0.
  - Pop on out_valid&out_ready.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - Space is reserved at accept time (count<DEPTH), so push never overflows.
  - Push into empty buffer: entry appears at the head the next cycle; no same-cycle bypass.
- flush priority: clears buffer (count<=0, out_valid<=0) at the edge, overriding simultaneous push/pop. out_instr/out_pc values after flush are don't-care but must not glitch out_valid.
- Reset mid-operation: immediate return to reset values regardless of state. An outstanding memory request is abandoned; memory is reset on the same reset.
- PC values are carried verbatim; no arithmetic in this block. The PC wraps 31->0 upstream with no special handling here.

Decomposition:
- Shared package fetch_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, DROP=2'd2); PC_W/INSTR_W defaults; fetch-entry width constant (PC_W+INSTR_W).
- One sub-module: fetch_buffer, a 2-entry synchronous FIFO with push/pop/clear, count, and head outputs, using the same clk/reset.

Test Plan:
- Reset release, zero-wait memory (ack same cycle as req), pc_valid=1, pc=5'b00100, out_ready=1:
  - mem_addr=4, mem_req=1 one cycle after accept.
  - rdata=16'hA5A5 gives out_valid=1, out_pc=4, out_instr=16'hA5A5 the following cycle.
- Memory ack delayed 3 cycles:
  - mem_req and mem_addr stable for all 3 cycles.
  - pc_ready=0 throughout WAIT.
  - out_valid rises exactly 1 cycle after mem_ack.
- out_ready=0, fetch pc=1,2,3:
  - After two pushes count=2, pc_ready=0, and pc=3 is not accepted.
  - Raise out_ready: head out_pc=1, then 2, in order; pc=3 is accepted once a slot frees.
- Flush in WAIT before ack, buffer holding 1 entry:
  - out_valid=0 next cycle; state goes DROP.
  - Late ack (rdata=16'hDEAD) never appears at the output; pc_ready returns 1 after the ack.
- Flush coincident with mem_ack: data dropped, no out_valid, state IDLE, mem_req=0 next cycle.
- reset pulsed low asynchronously mid-WAIT (between clock edges): mem_req, out_valid and pc_ready go 0 immediately, without waiting for a clk edge.
